// File: rtl/flag_ctrl.sv
// -----------------------------------------------------------------------------
// flag_ctrl
//   Sequencing controller for the 4-bit CPU flag register {C,V,N,Z}.
//   Arbitrates flag writers (masked ALU updates, shadow-stack save/restore
//   used on interrupt entry/exit) and evaluates branch condition codes on
//   settled flags. Drives the flag register's write-enable/data and reads
//   its outputs back through flags_q.
//
//   Optional feature macro: FLAG_CTRL_FWD_EN
//     defined   : conditions may also be accepted in COMMIT and evaluate on
//                 the in-flight write data (flag_d), removing the stall.
//     undefined : no condition is accepted during COMMIT.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   alu_valid/ready   ALU update request / acceptance, alu_flags + update_mask
//   save_req          push flags_q onto shadow stack -> save_ack / save_err
//   restore_req       pop shadow stack into flag register -> restore_ack/_err
//   cond_valid/ready  condition request / acceptance, cond_code selector
//   cond_done/taken   result pulse / held result
//   flags_q           flag register outputs
//   flag_we, flag_d   flag register write-enable and data
//   stack_count       snapshots currently held
//
// Handshake semantics: every request is level-held by its source until it is
// serviced. alu_valid/cond_valid are accepted in a cycle where the matching
// ready is high; save_req/restore_req are serviced in a cycle where they win
// the fixed priority restore > alu > save > cond while the FSM is IDLE. The
// source drops a request on the clock edge at which it is serviced.
// -----------------------------------------------------------------------------
module flag_ctrl #(
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               alu_valid,
  output logic                               alu_ready,
  input  logic [3:0]                         alu_flags,
  input  logic [3:0]                         update_mask,
  input  logic                               save_req,
  output logic                               save_ack,
  output logic                               save_err,
  input  logic                               restore_req,
  output logic                               restore_ack,
  output logic                               restore_err,
  input  logic                               cond_valid,
  output logic                               cond_ready,
  input  logic [3:0]                         cond_code,
  output logic                               cond_done,
  output logic                               cond_taken,
  input  logic [3:0]                         flags_q,
  output logic                               flag_we,
  output logic [3:0]                         flag_d,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t state;

  logic [3:0]    stack_mem [STACK_DEPTH];
  logic [IW-1:0] top_idx;
  logic [IW-1:0] push_idx;

  logic is_idle;
  logic grant_restore;
  logic grant_alu;
  logic grant_save;
  logic grant_cond;
  logic cond_gate;
  logic stack_full;
  logic stack_empty;
  logic push_en;
  logic [3:0] merged;
  logic [3:0] cond_src;

  // Condition evaluation on a {C,V,N,Z} vector.
  function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
    logic c, v, n, z;
    {c, v, n, z} = f;
    case (code)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return c;
      4'd3:    return !c;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return c & !z;
      4'd9:    return !c | z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z & (n == v);
      4'd13:   return z | (n != v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign is_idle     = (state == IDLE);
  assign stack_full  = (stack_count == CW'(STACK_DEPTH));
  assign stack_empty = (stack_count == '0);
  assign top_idx     = IW'(stack_count - 1'b1);
  assign push_idx    = IW'(stack_count);

  assign grant_restore = is_idle & restore_req;
  assign grant_alu     = is_idle & !restore_req & alu_valid;
  assign grant_save    = is_idle & !restore_req & !alu_valid & save_req;
  assign push_en       = grant_save & !stack_full;

  assign alu_ready = is_idle & !restore_req;

`ifdef FLAG_CTRL_FWD_EN
  // In COMMIT the value being written is already on flag_d; evaluating on it
  // gives the same answer a condition would see one cycle later.
  assign cond_gate = 1'b1;
  assign cond_src  = is_idle ? flags_q : flag_d;
`else
  assign cond_gate = is_idle;
  assign cond_src  = flags_q;
`endif

  assign cond_ready = cond_gate & !restore_req & !alu_valid & !save_req;
  assign grant_cond = cond_ready & cond_valid;

  assign merged = (alu_flags & update_mask) | (flags_q & ~update_mask);

  // Snapshot storage needs no reset: entries are only read below stack_count.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= flags_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      stack_count <= '0;
      flag_we     <= 1'b0;
      flag_d      <= 4'b0000;
      save_ack    <= 1'b0;
      save_err    <= 1'b0;
      restore_ack <= 1'b0;
      restore_err <= 1'b0;
      cond_done   <= 1'b0;
      cond_taken  <= 1'b0;
    end else begin
      flag_we     <= 1'b0;
      save_ack    <= 1'b0;
      save_err    <= 1'b0;
      restore_ack <= 1'b0;
      restore_err <= 1'b0;
      cond_done   <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_restore) begin
            if (!stack_empty) begin
              flag_we     <= 1'b1;
              flag_d      <= stack_mem[top_idx];
              restore_ack <= 1'b1;
              stack_count <= stack_count - 1'b1;
              state       <= COMMIT;
            end else begin
              restore_err <= 1'b1;
            end
          end else if (grant_alu) begin
            // An all-zero mask is accepted but writes nothing.
            if (update_mask != 4'b0000) begin
              flag_we <= 1'b1;
              flag_d  <= merged;
              state   <= COMMIT;
            end
          end else if (grant_save) begin
            if (!stack_full) begin
              save_ack    <= 1'b1;
              stack_count <= stack_count + 1'b1;
            end else begin
              save_err <= 1'b1;
            end
          end
        end
        COMMIT: begin
          // One cycle for the register to capture flag_d; this also keeps
          // flag_we from being high on two consecutive cycles.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (grant_cond) begin
        cond_done  <= 1'b1;
        cond_taken <= eval_cond(cond_code, cond_src);
      end
    end
  end

endmodule

// File: doc/flag_ctrl.md
Name: flag_ctrl

Overview:
Sequencing controller for the 4-bit CPU flag register (C, V, N, Z). It arbitrates flag writers: ALU updates with a per-flag mask, and save/restore through a small shadow stack used on interrupt entry and exit. It also evaluates branch condition codes against the settled flags, with a hazard interlock. It sits between the ALU/control unit and the flag register, driving that register's write-enable and data inputs and reading back its outputs.

Parameters:
STACK_DEPTH, 4, number of flag snapshots held by the shadow stack (>=1).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU flag-update request
alu_ready  output  1  ALU update accepted this cycle when alu_valid=1
alu_flags  input  4  {C,V,N,Z} produced by ALU
update_mask  input  4  1 = overwrite that flag, 0 = keep current value
save_req  input  1  push current flags onto shadow stack
save_ack  output  1  one-cycle pulse: save completed
save_err  output  1  one-cycle pulse: save dropped, stack full
restore_req  input  1  pop stack into flag register
restore_ack  output  1  one-cycle pulse: restore write issued
restore_err  output  1  one-cycle pulse: restore dropped, stack empty
cond_valid  input  1  condition evaluation request
cond_ready  output  1  condition request accepted
cond_code  input  4  condition selector
cond_done  output  1  one-cycle pulse: cond_taken valid
cond_taken  output  1  evaluated condition result
flags_q  input  4  {C,V,N,Z} from flag register outputs
flag_we  output  1  flag register write-enable
flag_d  output  4  {C,V,N,Z} to flag register inputs
stack_count  output  $clog2(STACK_DEPTH+1)  snapshots currently held

Behaviour:
- Reset (async, rst_n=0): state IDLE; stack empty, stack_count=0; flag_we=0, flag_d=0; all ack/err/done pulses 0; cond_taken=0. A pending write in flight is discarded.
- States: IDLE, COMMIT.
  - IDLE to COMMIT when a flag-modifying op is granted with a write.
  - COMMIT to IDLE unconditionally after 1 cycle.
- Grants: one op per cycle, IDLE only. Fixed priority: restore > alu > save > cond.
  - Requests are level-held until serviced.
  - alu_ready = IDLE & !restore_req.
  - cond_ready = IDLE & !restore_req & !alu_valid & !save_req.
- ALU grant at cycle T:
  - Next cycle (T+1) flag_we=1 and flag_d = (alu_flags & update_mask) | (flags_q & ~update_mask).
  - The register holds the new value from T+2.
  - update_mask=0: request is accepted, no write, state stays IDLE.
- Save grant at T (stack not full): push flags_q; save_ack=1 at T+1; stack_count +1.
- Save at T with stack full: save_err=1 at T+1; no push.
- Restore grant at T (stack not empty):
  - Pop the top entry (LIFO).
  - At T+1: flag_we=1, flag_d=popped value, restore_ack=1, state COMMIT.
- Restore at T with stack empty: restore_err=1 at T+1; no write.
- Condition accepted at T: evaluate on flags_q at T; cond_done=1 and cond_taken valid at T+1. cond_taken holds its value until the next evaluation.
- Condition codes:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 NV 0
- Hazard: no cond accepted during COMMIT, so a condition always sees committed flags.
- flag_we is never high for two consecutive cycles, so maximum flag-write throughput is 1 per 2 cycles.
- Simultaneous save_req and restore_req: restore wins; save is serviced in a later IDLE cycle.

Optional Feature:
Macro FLAG_CTRL_FWD_EN.
- Defined: cond_ready is also asserted in COMMIT (subject to the same priority masks). A condition accepted in COMMIT evaluates on flag_d (forwarded) instead of flags_q, removing the 1-cycle stall.
- Undefined: cond_ready=0 during COMMIT, as in the base behaviour.

Test Plan:
- Reset mid-COMMIT (flag_we=1): assert rst_n=0 -> flag_we=0, stack_count=0, state IDLE immediately, before the next clk edge.
- flags_q=4'b0101, alu_flags=4'b1010, mask=4'b1100, alu_valid at T -> T+1 flag_we=1, flag_d=4'b1001; alu_ready=0 at T+1.
- Save flags 0001, 0010, 0100, 1000, then save again (depth 4) -> four save_acks, stack_count=4, then save_err. Then 4 restores -> flag_d sequence 1000, 0100, 0010, 0001, then restore_err.
- flags_q=4'b0011 (N=1, Z=1); cond_code 12 (GT) -> cond_taken=0; cond_code 13 (LE) -> 1; cond_code 10 (GE) -> 0; cond_code 15 -> 0. Each result arrives with cond_done 1 cycle after accept.
- alu_valid, save_req, cond_valid and restore_req all asserted in the same cycle -> grant order restore, alu, save, cond. Cond is accepted only after the last COMMIT returns to IDLE and sees the final flags.
- FLAG_CTRL_FWD_EN defined: ALU write Z=1 at T, cond EQ presented at T+1 -> accepted at T+1, cond_taken=1 at T+2. Macro undefined -> accepted at T+2, result at T+3.
